queue_dispatch: RTL

QUEUE_DISPATCH -- requirements
Module: queue_dispatch

---
 rtl/queue_dispatch.sv | 141 ++++++++++++++
 1 files changed

// File: rtl/queue_dispatch.sv
// queue_dispatch: two-entry registered skid FIFO between an upstream circular
// FIFO and a valid/ready consumer. Each popped entry is stamped with a wrapping
// sequence tag. Optional transfer statistics are enabled by defining
// QUEUE_DISPATCH_STATS_EN, which adds the dispatchCount_OUT port.
module queue_dispatch #(
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned TAG_WIDTH  = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  qEmpty_IN,
    input  logic [DATA_WIDTH-1:0] qData_IN,
    output logic                  qPopReq_OUT,
    input  logic                  flush_IN,
    output logic                  valid_OUT,
    output logic [DATA_WIDTH-1:0] data_OUT,
    output logic [TAG_WIDTH-1:0]  tag_OUT,
    input  logic                  ready_IN
`ifdef QUEUE_DISPATCH_STATS_EN
    ,
    output logic [15:0]           dispatchCount_OUT
`endif
);

    localparam int unsigned COUNT_WIDTH = 16;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        TWO   = 2'd2
    } occState_t;

    occState_t             occState, occStateNext;
    logic [DATA_WIDTH-1:0] headData, headDataNext;
    logic [TAG_WIDTH-1:0]  headTag, headTagNext;
    logic [DATA_WIDTH-1:0] tailData, tailDataNext;
    logic [TAG_WIDTH-1:0]  tailTag, tailTagNext;
    logic [TAG_WIDTH-1:0]  tagCount, tagCountNext;
    logic                  popReq;
    logic                  xfer;

`ifdef QUEUE_DISPATCH_STATS_EN
    logic [COUNT_WIDTH-1:0] dispatchCount, dispatchCountNext;
`endif

    // State, slot and counter registers; reset overrides flush, pop and transfer
    always_ff @(posedge clk) begin
        if (reset) begin
            occState <= EMPTY;
            headData <= '0;
            headTag  <= '0;
            tailData <= '0;
            tailTag  <= '0;
            tagCount <= '0;
`ifdef QUEUE_DISPATCH_STATS_EN
            dispatchCount <= '0;
`endif
        end else begin
            occState <= occStateNext;
            headData <= headDataNext;
            headTag  <= headTagNext;
            tailData <= tailDataNext;
            tailTag  <= tailTagNext;
            tagCount <= tagCountNext;
`ifdef QUEUE_DISPATCH_STATS_EN
            dispatchCount <= dispatchCountNext;
`endif
        end
    end

    // Next-state, slot movement and tag/statistics update
    always_comb begin
        popReq       = !qEmpty_IN && !flush_IN && !reset && (occState != TWO);
        xfer         = (occState != EMPTY) && ready_IN && !flush_IN && !reset;
        occStateNext = occState;
        headDataNext = headData;
        headTagNext  = headTag;
        tailDataNext = tailData;
        tailTagNext  = tailTag;
        tagCountNext = tagCount;
`ifdef QUEUE_DISPATCH_STATS_EN
        dispatchCountNext = dispatchCount;
        if (xfer) begin
            dispatchCountNext = dispatchCount + COUNT_WIDTH'(1);
        end
`endif

        if (popReq) begin
            tagCountNext = tagCount + TAG_WIDTH'(1);
        end

        case (occState)
            EMPTY: begin
                if (popReq) begin
                    occStateNext = ONE;
                    headDataNext = qData_IN;
                    headTagNext  = tagCount;
                end
            end
            ONE: begin
                if (popReq && xfer) begin
                    // Head leaves and the new entry takes its place directly
                    headDataNext = qData_IN;
                    headTagNext  = tagCount;
                end else if (popReq) begin
                    occStateNext = TWO;
                    tailDataNext = qData_IN;
                    tailTagNext  = tagCount;
                end else if (xfer) begin
                    occStateNext = EMPTY;
                end
            end
            TWO: begin
                if (xfer) begin
                    occStateNext = ONE;
                    headDataNext = tailData;
                    headTagNext  = tailTag;
                end
            end
            default: begin
                occStateNext = EMPTY;
            end
        endcase

        if (flush_IN) begin
            occStateNext = EMPTY;
        end
    end

    // Output presentation: oldest entry, zeroed when nothing is held
    always_comb begin
        qPopReq_OUT = popReq;
        valid_OUT   = (occState != EMPTY) && !reset;
        data_OUT    = valid_OUT ? headData : '0;
        tag_OUT     = valid_OUT ? headTag : '0;
`ifdef QUEUE_DISPATCH_STATS_EN
        dispatchCount_OUT = dispatchCount;
`endif
    end

endmodule
